// File: rtl/pipeline_exec_controller.sv
// Execution/debug sequencer for the 5-stage pipeline: owns the global freeze,
// runs RUN/STEP/HALT/DUMP commands, drains on end of program and streams the register bank.
`timescale 1ns/1ps

module pipeline_exec_controller #(
    parameter int NB_DATA      = 32,
    parameter int NB_ADDR      = 5,
    parameter int N_REGS       = 32,
    parameter int DRAIN_CYCLES = 4,
    parameter int NB_CYC       = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    input  logic [1:0]         i_cmd,
    output logic               o_cmd_ready,
    input  logic               i_end_of_program,
    output logic               o_halt,
    output logic               o_program_done,
    output logic               o_dbg_reg_sel,
    output logic [NB_ADDR-1:0] o_dbg_reg_addr,
    input  logic [NB_DATA-1:0] i_dbg_reg_data,
    output logic               o_dump_valid,
    input  logic               i_dump_ready,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic               o_dump_last,
    output logic [NB_CYC-1:0]  o_cycle_count,
    output logic [2:0]         o_dbg_state
);

    localparam logic [1:0] CMD_RUN  = 2'd0;
    localparam logic [1:0] CMD_STEP = 2'd1;
    localparam logic [1:0] CMD_HALT = 2'd2;
    localparam logic [1:0] CMD_DUMP = 2'd3;

    localparam int NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [NB_DRAIN-1:0] DRAIN_INIT = NB_DRAIN'(DRAIN_CYCLES - 1);
    localparam logic [NB_ADDR-1:0]  LAST_IDX   = NB_ADDR'(N_REGS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        STEP     = 3'd2,
        DRAIN    = 3'd3,
        DONE     = 3'd4,
        DUMP_RD  = 3'd5,
        DUMP_OUT = 3'd6
    } state_t;

    state_t              state;
    state_t              ret_state;
    logic [NB_DRAIN-1:0] drain_cnt;
    logic [NB_ADDR-1:0]  dump_idx;
    logic                cmd_fire;

    // Both ports use valid/ready: a transfer happens on a rising edge where valid && ready;
    // once raised, the sender holds valid and its payload unchanged until that edge.
    assign cmd_fire       = i_cmd_valid && o_cmd_ready;
    assign o_dbg_reg_addr = dump_idx;
    assign o_dbg_state    = state;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state          <= IDLE;
            ret_state      <= IDLE;
            drain_cnt      <= '0;
            dump_idx       <= '0;
            o_cmd_ready    <= 1'b1;
            o_halt         <= 1'b1;
            o_program_done <= 1'b0;
            o_dbg_reg_sel  <= 1'b0;
            o_dump_valid   <= 1'b0;
            o_dump_data    <= '0;
            o_dump_last    <= 1'b0;
            o_cycle_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        case (i_cmd)
                            CMD_RUN: begin
                                state  <= RUN;
                                o_halt <= 1'b0;
                            end
                            CMD_STEP: begin
                                state       <= STEP;
                                o_halt      <= 1'b0;
                                o_cmd_ready <= 1'b0;
                            end
                            CMD_DUMP: begin
                                state         <= DUMP_RD;
                                ret_state     <= IDLE;
                                dump_idx      <= '0;
                                o_dbg_reg_sel <= 1'b1;
                                o_cmd_ready   <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end

                RUN: begin
                    o_cycle_count <= o_cycle_count + NB_CYC'(1);
                    // The HALT opcode in ID wins: older instructions must still retire.
                    if (i_end_of_program) begin
                        state       <= DRAIN;
                        drain_cnt   <= DRAIN_INIT;
                        o_cmd_ready <= 1'b0;
                    end else if (cmd_fire && i_cmd == CMD_HALT) begin
                        state  <= IDLE;
                        o_halt <= 1'b1;
                    end
                end

                STEP: begin
                    o_cycle_count <= o_cycle_count + NB_CYC'(1);
                    if (i_end_of_program) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_INIT;
                    end else begin
                        state       <= IDLE;
                        o_halt      <= 1'b1;
                        o_cmd_ready <= 1'b1;
                    end
                end

                DRAIN: begin
                    o_cycle_count <= o_cycle_count + NB_CYC'(1);
                    if (drain_cnt == '0) begin
                        state          <= DONE;
                        o_halt         <= 1'b1;
                        o_program_done <= 1'b1;
                        o_cmd_ready    <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - NB_DRAIN'(1);
                    end
                end

                DONE: begin
                    if (cmd_fire && i_cmd == CMD_DUMP) begin
                        state         <= DUMP_RD;
                        ret_state     <= DONE;
                        dump_idx      <= '0;
                        o_dbg_reg_sel <= 1'b1;
                        o_cmd_ready   <= 1'b0;
                    end
                end

                // The bank read is combinational, so the word is captured one cycle after the address.
                DUMP_RD: begin
                    state        <= DUMP_OUT;
                    o_dump_data  <= i_dbg_reg_data;
                    o_dump_valid <= 1'b1;
                    o_dump_last  <= (dump_idx == LAST_IDX);
                end

                DUMP_OUT: begin
                    if (i_dump_ready) begin
                        o_dump_valid <= 1'b0;
                        if (o_dump_last) begin
                            state         <= ret_state;
                            o_dump_last   <= 1'b0;
                            o_dbg_reg_sel <= 1'b0;
                            dump_idx      <= '0;
                            o_cmd_ready   <= 1'b1;
                        end else begin
                            state    <= DUMP_RD;
                            dump_idx <= dump_idx + NB_ADDR'(1);
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    o_halt      <= 1'b1;
                    o_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// Directed bench for pipeline_exec_controller: command sequencing, drain, cycle count
// and the register dump stream under steady and random back-pressure.
`timescale 1ns/1ps

module tb_pipeline_exec_controller;

    localparam logic [1:0] CMD_RUN  = 2'd0;
    localparam logic [1:0] CMD_STEP = 2'd1;
    localparam logic [1:0] CMD_HALT = 2'd2;
    localparam logic [1:0] CMD_DUMP = 2'd3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic        i_clk;
    logic        i_reset;
    logic        i_cmd_valid;
    logic [1:0]  i_cmd;
    logic        o_cmd_ready;
    logic        i_end_of_program;
    logic        o_halt;
    logic        o_program_done;
    logic        o_dbg_reg_sel;
    logic [4:0]  o_dbg_reg_addr;
    logic [31:0] i_dbg_reg_data;
    logic        o_dump_valid;
    logic        i_dump_ready;
    logic [31:0] o_dump_data;
    logic        o_dump_last;
    logic [31:0] o_cycle_count;
    logic [2:0]  o_dbg_state;

    pipeline_exec_controller dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_cmd_valid      (i_cmd_valid),
        .i_cmd            (i_cmd),
        .o_cmd_ready      (o_cmd_ready),
        .i_end_of_program (i_end_of_program),
        .o_halt           (o_halt),
        .o_program_done   (o_program_done),
        .o_dbg_reg_sel    (o_dbg_reg_sel),
        .o_dbg_reg_addr   (o_dbg_reg_addr),
        .i_dbg_reg_data   (i_dbg_reg_data),
        .o_dump_valid     (o_dump_valid),
        .i_dump_ready     (i_dump_ready),
        .o_dump_data      (o_dump_data),
        .o_dump_last      (o_dump_last),
        .o_cycle_count    (o_cycle_count),
        .o_dbg_state      (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    // ---------------- register bank model ----------------
    logic [31:0] regs [32];
    assign i_dbg_reg_data = o_dbg_reg_sel ? regs[o_dbg_reg_addr] : 32'hdead_beef;

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    int          low_cnt = 0;
    logic [32:0] exp_q [$];
    int          rd_ptr = 0;
    logic        mon_en = 1'b0;
    logic        rand_ready = 1'b0;
    logic        rdy_now;
    logic        hs_now;
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic [32:0] prev_word = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_reset && !o_halt) low_cnt++;
    end

    // Dump consumer: picks ready for the coming edge, checks hold-while-stalled and each accepted word.
    always @(negedge i_clk) begin
        rdy_now = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        i_dump_ready = rdy_now;
        if (!mon_en || i_reset) begin
            rd_ptr     = 0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_valid && !prev_hs) begin
                check_val("hold_valid", 64'(o_dump_valid), 64'd1);
                check_val("hold_word", 64'({o_dump_last, o_dump_data}), 64'(prev_word));
            end
            hs_now = o_dump_valid && rdy_now;
            if (hs_now) begin
                if (rd_ptr < exp_q.size())
                    check_val("dump_word", 64'({o_dump_last, o_dump_data}), 64'(exp_q[rd_ptr]));
                else
                    check_val("dump_extra", 64'(rd_ptr), 64'(exp_q.size()));
                rd_ptr++;
            end
            prev_valid = o_dump_valid;
            prev_hs    = hs_now;
            prev_word  = {o_dump_last, o_dump_data};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        @(negedge i_clk);
        i_cmd_valid = 1'b1;
        i_cmd       = c;
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic pulse_eop(input logic with_halt);
        @(negedge i_clk);
        i_end_of_program = 1'b1;
        i_cmd_valid      = with_halt;
        i_cmd            = CMD_HALT;
        @(posedge i_clk);
        #1;
        i_end_of_program = 1'b0;
        i_cmd_valid      = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, output int cyc);
        cyc = 0;
        while (o_dbg_state != st && cyc < budget) begin
            @(posedge i_clk);
            #1;
            cyc++;
        end
        if (o_dbg_state != st) check_val("wait_timeout", 64'(o_dbg_state), 64'(st));
    endtask

    task automatic arm_dump(input logic random_ready);
        mon_en = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back({(i == 31), 32'(i * 3)});
        @(negedge i_clk);
        #1;
        rand_ready = random_ready;
        mon_en     = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int low0;
        int cyc;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
        i_reset          = 1'b1;
        i_cmd_valid      = 1'b0;
        i_cmd            = CMD_RUN;
        i_end_of_program = 1'b0;
        do_reset();

        // Reset and idle
        repeat (10) @(posedge i_clk);
        #1;
        check_val("idle_halt", 64'(o_halt), 64'd1);
        check_val("idle_ready", 64'(o_cmd_ready), 64'd1);
        check_val("idle_count", 64'(o_cycle_count), 64'd0);
        check_val("idle_dump_valid", 64'(o_dump_valid), 64'd0);
        check_val("idle_sel", 64'(o_dbg_reg_sel), 64'd0);
        check_val("idle_done", 64'(o_program_done), 64'd0);
        send_cmd(CMD_HALT);
        check_val("idle_halt_ignored", 64'(o_dbg_state), 64'(S_IDLE));

        // Three single steps
        for (int s = 0; s < 3; s++) begin
            low0 = low_cnt;
            send_cmd(CMD_STEP);
            repeat (3) @(posedge i_clk);
            #1;
            check_val("step_low_cycles", 64'(low_cnt - low0), 64'd1);
            check_val("step_back_idle", 64'(o_dbg_state), 64'(S_IDLE));
        end
        check_val("step_count", 64'(o_cycle_count), 64'd3);

        // RUN then HALT, with a DUMP ignored while running
        do_reset();
        low0 = low_cnt;
        send_cmd(CMD_RUN);
        repeat (9) @(posedge i_clk);
        send_cmd(CMD_DUMP);
        check_val("run_dump_ignored", 64'(o_dbg_state), 64'(S_RUN));
        repeat (10) @(posedge i_clk);
        send_cmd(CMD_HALT);
        check_val("run_halted", 64'(o_halt), 64'd1);
        repeat (5) @(posedge i_clk);
        #1;
        check_val("run_low_cycles", 64'(low_cnt - low0), 64'd21);
        check_val("run_count", 64'(o_cycle_count), 64'd21);
        check_val("run_state_idle", 64'(o_dbg_state), 64'(S_IDLE));

        // End of program with drain
        do_reset();
        low0 = low_cnt;
        send_cmd(CMD_RUN);
        repeat (7) @(posedge i_clk);
        pulse_eop(1'b0);
        check_val("drain_state", 64'(o_dbg_state), 64'(S_DRAIN));
        check_val("drain_ready", 64'(o_cmd_ready), 64'd0);
        wait_state(S_DONE, 20, cyc);
        check_val("eop_done", 64'(o_program_done), 64'd1);
        check_val("eop_count", 64'(o_cycle_count), 64'd12);
        check_val("eop_low_cycles", 64'(low_cnt - low0), 64'd12);
        send_cmd(CMD_RUN);
        check_val("done_run_ignored", 64'(o_dbg_state), 64'(S_DONE));
        check_val("done_halt", 64'(o_halt), 64'd1);

        // End of program with a simultaneous HALT command
        do_reset();
        send_cmd(CMD_RUN);
        repeat (7) @(posedge i_clk);
        pulse_eop(1'b1);
        wait_state(S_DONE, 20, cyc);
        check_val("eop_halt_done", 64'(o_program_done), 64'd1);
        check_val("eop_halt_count", 64'(o_cycle_count), 64'd12);

        // End of program seen during a STEP
        do_reset();
        send_cmd(CMD_STEP);
        pulse_eop(1'b0);
        wait_state(S_DONE, 20, cyc);
        check_val("step_eop_count", 64'(o_cycle_count), 64'd5);
        check_val("step_eop_done", 64'(o_program_done), 64'd1);

        // Full dump from DONE with the consumer always ready
        arm_dump(1'b0);
        low0 = low_cnt;
        send_cmd(CMD_DUMP);
        wait_state(S_DONE, 100, cyc);
        check_val("dump_cycles", 64'(cyc), 64'd64);
        check_val("dump_words", 64'(rd_ptr), 64'd32);
        check_val("dump_sel_off", 64'(o_dbg_reg_sel), 64'd0);
        check_val("dump_valid_off", 64'(o_dump_valid), 64'd0);
        check_val("dump_halt_low", 64'(low_cnt - low0), 64'd0);
        check_val("dump_count_held", 64'(o_cycle_count), 64'd5);
        check_val("dump_done_kept", 64'(o_program_done), 64'd1);

        // Full dump with random back-pressure
        arm_dump(1'b1);
        send_cmd(CMD_DUMP);
        wait_state(S_DONE, 400, cyc);
        check_val("rdump_words", 64'(rd_ptr), 64'd32);

        // Dump interrupted by reset after ten words
        arm_dump(1'b1);
        send_cmd(CMD_DUMP);
        cyc = 0;
        while (rd_ptr < 10 && cyc < 200) begin
            @(negedge i_clk);
            cyc++;
        end
        check_val("mid_dump_reached", 64'(rd_ptr >= 10), 64'd1);
        #2;
        mon_en  = 1'b0;
        i_reset = 1'b1;
        #1;
        check_val("rst_state", 64'(o_dbg_state), 64'(S_IDLE));
        check_val("rst_halt", 64'(o_halt), 64'd1);
        check_val("rst_dump_valid", 64'(o_dump_valid), 64'd0);
        check_val("rst_dump_last", 64'(o_dump_last), 64'd0);
        check_val("rst_dump_data", 64'(o_dump_data), 64'd0);
        check_val("rst_sel", 64'(o_dbg_reg_sel), 64'd0);
        check_val("rst_addr", 64'(o_dbg_reg_addr), 64'd0);
        check_val("rst_done", 64'(o_program_done), 64'd0);
        check_val("rst_count", 64'(o_cycle_count), 64'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;

        // Dump from IDLE returns to IDLE
        arm_dump(1'b0);
        send_cmd(CMD_DUMP);
        wait_state(S_IDLE, 100, cyc);
        check_val("idle_dump_cycles", 64'(cyc), 64'd64);
        check_val("idle_dump_words", 64'(rd_ptr), 64'd32);
        check_val("idle_dump_ready", 64'(o_cmd_ready), 64'd1);
        mon_en = 1'b0;

        repeat (2) @(posedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
